// File: rtl/lnl_pattern_selector.sv
// LED pattern selector: debounced buttons latch one of CHANNEL_COUNT pattern channels onto the LED bank.
// Define LNL_AUTO_CYCLE_EN to make the latched channel auto-advance every AUTO_TICKS ticks while running.
module lnl_pattern_selector #(
  parameter int CHANNEL_COUNT = 4,
  parameter int LED_COUNT     = 4,
  parameter int DELAY         = 24,
  parameter int DEBOUNCE      = 16,
  parameter int AUTO_TICKS    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNEL_COUNT-1:0]           btns,
  input  logic [CHANNEL_COUNT*LED_COUNT-1:0] ch_leds,
  output logic [LED_COUNT-1:0]               leds,
  output logic [CHANNEL_COUNT-1:0]           active_ch,
  output logic                               fault
);
  // state   | meaning
  // S_IDLE  | nothing latched, LEDs all on
  // S_RUN   | latched channel drives the LEDs
  // S_FAULT | two or more buttons held, alternating pattern paced by tick

  localparam int SEL_W = $clog2(CHANNEL_COUNT);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  if (CHANNEL_COUNT < 2 || LED_COUNT < 2 || DEBOUNCE < 2 || DELAY < 1 || AUTO_TICKS < 1) begin : g_param_check
    $error("lnl_pattern_selector: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

  state_t                   state, state_next;
  logic [SEL_W-1:0]         sel, sel_next, rise_idx;
  logic [CHANNEL_COUNT-1:0] sync1, sync2, db, db_q, rise;
  logic [CNT_W-1:0]         db_cnt [CHANNEL_COUNT];
  logic [DELAY-1:0]         tick_cnt;
  logic                     tick, phase, multi, rise_any;
  logic [LED_COUNT-1:0]     alt, leds_next;

  // A level flips only after DEBOUNCE+1 consecutive differing samples, so db moves
  // DEBOUNCE+2 edges after the raw change is first sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btns;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE)) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise     = db & ~db_q;
  assign rise_any = |rise;
  assign multi    = $countones(db) >= 2;
  assign tick     = &tick_cnt;

  always_comb begin
    rise_idx = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      if (rise[i]) rise_idx = SEL_W'(i);
  end

  always_comb begin
    for (int j = 0; j < LED_COUNT; j++)
      alt[j] = (j % 2 == 0) ? ~phase : phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt + DELAY'(1);
      phase    <= phase ^ tick;
    end
  end

`ifdef LNL_AUTO_CYCLE_EN
  localparam int AUTO_W = $clog2(AUTO_TICKS + 1);
  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_adv;

  assign auto_adv = (state == S_RUN) && !multi && !rise_any && tick &&
                    (auto_cnt == AUTO_W'(AUTO_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst || state != S_RUN || state_next != S_RUN || rise_any || auto_adv)
      auto_cnt <= '0;
    else if (tick)
      auto_cnt <= auto_cnt + AUTO_W'(1);
  end
`endif

  always_comb begin
    state_next = state;
    sel_next   = sel;
    if (multi) begin
      state_next = S_FAULT;
    end else begin
      case (state)
        S_FAULT: if (db == '0) state_next = S_IDLE;
        S_IDLE: begin
          if (rise_any) begin
            state_next = S_RUN;
            sel_next   = rise_idx;
          end
        end
        S_RUN: begin
          if (rise_any) begin
            if (rise_idx == sel) state_next = S_IDLE;
            else                 sel_next   = rise_idx;
          end
`ifdef LNL_AUTO_CYCLE_EN
          else if (auto_adv) begin
            sel_next = (sel == SEL_W'(CHANNEL_COUNT - 1)) ? '0 : sel + SEL_W'(1);
          end
`endif
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    leds_next = '1;
    case (state)
      S_RUN:   leds_next = ch_leds[int'(sel)*LED_COUNT +: LED_COUNT];
      S_FAULT: leds_next = alt;
      default: leds_next = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= '0;
      leds      <= '1;
      active_ch <= '0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      sel       <= sel_next;
      leds      <= leds_next;
      fault     <= (state_next == S_FAULT);
      active_ch <= (state_next == S_RUN) ? (CHANNEL_COUNT'(1) << sel_next) : '0;
    end
  end
endmodule
